// File: rtl/conv_single_sequencer.sv
// conv_single_sequencer: steps the single-PE datapath through the four 3x3 taps-per-position
// MAC sweeps of a 4x4 * 3x3 convolution, latches each result, then reads the 2x2 result out.
module conv_single_sequencer #(
    parameter int ZERO_IDX  = 25,
    parameter int FILT_BASE = 16,
    parameter int PE_LAT    = 1,
    parameter int BUF_LAT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [4:0] input_array_addr,
    output logic [4:0] filter_ceiling_array_addr,
    output logic       sys_en,
    output logic       pe_clear,
    output logic       buffer_we_en_C11,
    output logic       buffer_we_en_C12,
    output logic       buffer_we_en_C21,
    output logic       buffer_we_en_C22,
    output logic [1:0] buffer_read_addr,
    output logic       out_valid,
    output logic [1:0] out_index
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_WRITE, S_READ, S_RWAIT, S_DONE
    } state_e;

    localparam logic [4:0] ZERO_SEL = 5'(ZERO_IDX);
    localparam logic [4:0] FILT_SEL = 5'(FILT_BASE);
    localparam logic [1:0] PE_LAST  = 2'(PE_LAT - 1);
    localparam logic [1:0] BUF_LAST = 2'(BUF_LAT - 1);

    state_e state_q, state_d;
    logic [1:0] pos_q, pos_d;
    logic [3:0] tap_q, tap_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] we_q;
    logic [BUF_LAT-1:0] vld_q;
    logic [1:0] idx_q [BUF_LAT];
    logic       mac_d;
    logic       issue;
    logic [1:0] in_row;
    logic [1:0] in_col;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tap_d   = tap_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            pos_d   = 2'd0;
            tap_d   = 4'd0;
            row_d   = 2'd0;
            col_d   = 2'd0;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = start ? S_CLEAR : S_IDLE;
                    pos_d   = 2'd0;
                end
                S_CLEAR: begin
                    state_d = S_MAC;
                    tap_d   = 4'd0;
                    row_d   = 2'd0;
                    col_d   = 2'd0;
                end
                S_MAC: begin
                    state_d = (tap_q == 4'd8) ? S_DRAIN : S_MAC;
                    tap_d   = tap_q + 4'd1;
                    col_d   = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
                    row_d   = (col_q == 2'd2) ? row_q + 2'd1 : row_q;
                    cnt_d   = 2'd0;
                end
                S_DRAIN: begin
                    state_d = (cnt_q == PE_LAST) ? S_WRITE : S_DRAIN;
                    cnt_d   = (cnt_q == PE_LAST) ? 2'd0 : cnt_q + 2'd1;
                end
                S_WRITE: begin
                    state_d = (pos_q == 2'd3) ? S_READ : S_CLEAR;
                    pos_d   = pos_q + 2'd1;
                    cnt_d   = 2'd0;
                end
                S_READ: begin
                    state_d = (cnt_q == 2'd3) ? S_RWAIT : S_READ;
                    cnt_d   = cnt_q + 2'd1;
                end
                S_RWAIT: begin
                    state_d = (cnt_q == BUF_LAST) ? S_DONE : S_RWAIT;
                    cnt_d   = (cnt_q == BUF_LAST) ? 2'd0 : cnt_q + 2'd1;
                end
                S_DONE: begin
                    state_d = start ? S_CLEAR : S_IDLE;
                    pos_d   = 2'd0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    assign mac_d  = (state_d == S_MAC);
    assign in_row = row_d + {1'b0, pos_d[1]};
    assign in_col = col_d + {1'b0, pos_d[0]};
    assign issue  = !abort && (state_q == S_READ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                   <= S_IDLE;
            pos_q                     <= 2'd0;
            tap_q                     <= 4'd0;
            row_q                     <= 2'd0;
            col_q                     <= 2'd0;
            cnt_q                     <= 2'd0;
            input_array_addr          <= ZERO_SEL;
            filter_ceiling_array_addr <= ZERO_SEL;
            sys_en                    <= 1'b0;
            pe_clear                  <= 1'b0;
            we_q                      <= 4'd0;
            buffer_read_addr          <= 2'd0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            vld_q                     <= '0;
            for (int k = 0; k < BUF_LAT; k++) idx_q[k] <= 2'd0;
        end else begin
            state_q                   <= state_d;
            pos_q                     <= pos_d;
            tap_q                     <= tap_d;
            row_q                     <= row_d;
            col_q                     <= col_d;
            cnt_q                     <= cnt_d;
            input_array_addr          <= mac_d ? {1'b0, in_row, in_col} : ZERO_SEL;
            filter_ceiling_array_addr <= mac_d ? FILT_SEL + {1'b0, tap_d} : ZERO_SEL;
            sys_en                    <= mac_d;
            pe_clear                  <= (state_d == S_CLEAR);
            we_q                      <= (state_d == S_WRITE) ? 4'b0001 << pos_d : 4'b0000;
            buffer_read_addr          <= (state_d == S_READ)  ? cnt_d :
                                         (state_d == S_RWAIT) ? 2'd3 : 2'd0;
            busy                      <= (state_d != S_IDLE) && (state_d != S_DONE);
            done                      <= (state_d == S_DONE);
            // Readout flag/index follow the issued read address by BUF_LAT cycles; abort flushes them.
            vld_q[0]                  <= issue;
            idx_q[0]                  <= issue ? buffer_read_addr : 2'd0;
            for (int k = 1; k < BUF_LAT; k++) begin
                vld_q[k] <= !abort && vld_q[k-1];
                idx_q[k] <= abort ? 2'd0 : idx_q[k-1];
            end
        end
    end

    assign {buffer_we_en_C22, buffer_we_en_C21, buffer_we_en_C12, buffer_we_en_C11} = we_q;
    assign out_valid = vld_q[BUF_LAT-1];
    assign out_index = idx_q[BUF_LAT-1];

endmodule

// File: tb/tb_conv_single_sequencer.sv
// tb_conv_single_sequencer: two sequencer instances (1/1 and 3/2 latencies) checked each cycle
// against a cycle-offset model, plus a bench-side PE/buffer datapath checking the readout values.
module tb_conv_single_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] ia;
        logic [4:0] fa;
        logic       sys;
        logic       clr;
        logic [3:0] we;
        logic [1:0] rda;
        logic       ov;
        logic [1:0] oi;
        logic       bsy;
        logic       dn;
    } outs_t;

    wire        busy0, done0, sys0, clr0, ov0, busy1, done1, sys1, clr1, ov1;
    wire [4:0]  ia0, fa0, ia1, fa1;
    wire [3:0]  we0, we1;
    wire [1:0]  rda0, oi0, rda1, oi1;

    conv_single_sequencer u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy0), .done(done0),
        .input_array_addr(ia0), .filter_ceiling_array_addr(fa0), .sys_en(sys0), .pe_clear(clr0),
        .buffer_we_en_C11(we0[0]), .buffer_we_en_C12(we0[1]), .buffer_we_en_C21(we0[2]),
        .buffer_we_en_C22(we0[3]), .buffer_read_addr(rda0), .out_valid(ov0), .out_index(oi0)
    );

    conv_single_sequencer #(.PE_LAT(3), .BUF_LAT(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy1), .done(done1),
        .input_array_addr(ia1), .filter_ceiling_array_addr(fa1), .sys_en(sys1), .pe_clear(clr1),
        .buffer_we_en_C11(we1[0]), .buffer_we_en_C12(we1[1]), .buffer_we_en_C21(we1[2]),
        .buffer_we_en_C22(we1[3]), .buffer_read_addr(rda1), .out_valid(ov1), .out_index(oi1)
    );

    outs_t g0, g1;
    assign g0 = {ia0, fa0, sys0, clr0, we0, rda0, ov0, oi0, busy0, done0};
    assign g1 = {ia1, fa1, sys1, clr1, we1, rda1, ov1, oi1, busy1, done1};

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int T;
    bit act [2] = '{1'b0, 1'b0};
    int e [2] = '{0, 0};

    // Expected outputs purely from the run's cycle offset e (e=1 is the first CLEAR cycle).
    function automatic outs_t expect_o(bit a, int ee, int k);
        outs_t o;
        int pl, bl, per, r0, dn, p, q, t;
        pl = (k == 1) ? 3 : 1;
        bl = (k == 1) ? 2 : 1;
        o = '0;
        o.ia = 5'd25;
        o.fa = 5'd25;
        if (!a) return o;
        per = 11 + pl;
        r0 = 4 * per + 1;
        dn = r0 + 4 + bl;
        o.bsy = (ee < dn);
        o.dn = (ee == dn);
        if (ee <= 4 * per) begin
            p = (ee - 1) / per;
            q = (ee - 1) % per;
            if (q == 0) o.clr = 1'b1;
            else if (q <= 9) begin
                t = q - 1;
                o.sys = 1'b1;
                o.ia = 5'(4 * (p / 2 + t / 3) + p % 2 + t % 3);
                o.fa = 5'(16 + t);
            end else if (q == 10 + pl) o.we[p] = 1'b1;
        end
        if (ee >= r0 && ee < r0 + 4) o.rda = 2'(ee - r0);
        else if (ee >= r0 + 4 && ee < dn) o.rda = 2'd3;
        if (ee >= r0 + bl && ee < r0 + 4 + bl) begin
            o.ov = 1'b1;
            o.oi = 2'(ee - r0 - bl);
        end
        return o;
    endfunction

    function automatic int run_len(int k);
        return 4 * (11 + ((k == 1) ? 3 : 1)) + 5 + ((k == 1) ? 2 : 1);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk or negedge rst);
        for (int k = 0; k < 2; k++) begin
            if (!rst || abort) act[k] = 1'b0;
            else if (act[k]) begin
                if (e[k] == run_len(k)) begin
                    act[k] = start;
                    e[k] = 1;
                end else e[k] = e[k] + 1;
            end else if (start) begin
                act[k] = 1'b1;
                e[k] = 1;
            end
        end
    end

    // Bench-side datapath for instance 0: operand mux, PE (latency 1), result buffer (latency 1).
    logic [7:0]  av [16];
    logic [7:0]  bv [9];
    logic [31:0] acc = 32'd0;
    logic [31:0] bufm [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] dout = 32'd0;

    function automatic logic [31:0] val(logic [4:0] s);
        if (s < 5'd16) return 32'(av[s[3:0]]);
        if (s < 5'd25) return 32'(bv[s - 5'd16]);
        return 32'd0;
    endfunction

    function automatic logic [31:0] conv(int p);
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                sum = sum + 32'(av[4 * (p / 2 + i) + p % 2 + j]) * 32'(bv[3 * i + j]);
        return sum;
    endfunction

    always @(posedge clk) begin
        if (clr0) acc <= 32'd0;
        else if (sys0) acc <= acc + val(ia0) * val(fa0);
        for (int k = 0; k < 4; k++) if (we0[k]) bufm[k] <= acc;
        dout <= bufm[rda0];
    end

    int we0_at [4];
    int done0_at, we1_at3, nsys;
    int cap [4];
    int ia_cap [36];
    int fa_cap [36];
    int clr_q [$];

    task automatic clear_caps();
        for (int k = 0; k < 4; k++) begin
            we0_at[k] = -1;
            cap[k] = -1;
        end
        done0_at = -1;
        we1_at3 = -1;
        nsys = 0;
        clr_q.delete();
    endtask

    task automatic check_cycle();
        outs_t ex;
        ex = expect_o(act[0], e[0], 0);
        total++;
        if (g0 !== ex) begin
            bad++;
            $display("FAIL outs0 cyc=%0d got=%h exp=%h", cyc, g0, ex);
        end
        ex = expect_o(act[1], e[1], 1);
        total++;
        if (g1 !== ex) begin
            bad++;
            $display("FAIL outs1 cyc=%0d got=%h exp=%h", cyc, g1, ex);
        end
        if (ov0 === 1'b1) begin
            total++;
            if (dout !== conv(int'(oi0))) begin
                bad++;
                $display("FAIL data idx=%0d got=%0d exp=%0d", oi0, dout, conv(int'(oi0)));
            end
            cap[oi0] = int'(dout);
        end
        if (sys0 === 1'b1 && nsys < 36) begin
            ia_cap[nsys] = int'(ia0);
            fa_cap[nsys] = int'(fa0);
            nsys++;
        end
        for (int k = 0; k < 4; k++) if (we0[k] === 1'b1 && we0_at[k] < 0) we0_at[k] = cyc;
        if (done0 === 1'b1 && done0_at < 0) done0_at = cyc;
        if (we1[3] === 1'b1 && we1_at3 < 0) we1_at3 = cyc;
        if (clr0 === 1'b1) clr_q.push_back(cyc);
    endtask

    initial forever begin
        @(negedge clk);
        check_cycle();
    end

    task automatic chk(string n, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", n, got, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (act[0] || act[1] || busy0 || busy1); i++) step(1);
        total++;
        if (act[0] || act[1] || busy0 || busy1) begin
            bad++;
            $display("FAIL idle_timeout busy0=%0b busy1=%0b exp=0", busy0, busy1);
        end
        step(2);
    endtask

    int c11 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int c12 [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int c22 [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    int lit [4] = '{54, 63, 90, 99};

    initial begin
        for (int i = 0; i < 16; i++) av[i] = 8'(i + 1);
        for (int i = 0; i < 9; i++) bv[i] = 8'd1;
        clear_caps();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step(20);
        chk("idle_ia", int'(ia0), 25);
        chk("idle_fa", int'(fa0), 25);
        chk("idle_busy", int'(busy0), 0);

        // single run with a repeated start at T+30 that must be ignored
        clear_caps();
        T = cyc;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(29);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle();
        for (int k = 0; k < 4; k++) chk($sformatf("we0_C%0d_time", k), we0_at[k], T + 12 + 12 * k);
        chk("done0_time", done0_at, T + 54);
        chk("we1_C22_time", we1_at3, T + 56);
        chk("clear0_first", clr_q[0], T + 1);
        chk("clear0_second", clr_q[1], T + 13);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("c11_ia%0d", i), ia_cap[i], c11[i]);
            chk($sformatf("c11_fa%0d", i), fa_cap[i], 16 + i);
            chk($sformatf("c12_ia%0d", i), ia_cap[9 + i], c12[i]);
            chk($sformatf("c22_ia%0d", i), ia_cap[27 + i], c22[i]);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("result%0d", k), cap[k], lit[k]);

        // abort during C12 MAC
        clear_caps();
        T = cyc;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(19);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_busy", int'(busy0), 0);
        step(60);
        chk("abort_we_C11", we0_at[0], T + 12);
        chk("abort_we_C12", we0_at[1], -1);
        chk("abort_done", done0_at, -1);

        // fresh run after abort
        clear_caps();
        T = cyc;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle();
        chk("rerun_done", done0_at, T + 54);
        for (int k = 0; k < 4; k++) chk($sformatf("rerun_result%0d", k), cap[k], lit[k]);

        // start held continuously: back-to-back run
        clear_caps();
        T = cyc;
        start = 1'b1;
        step(60);
        start = 1'b0;
        wait_idle();
        chk("held_done", done0_at, T + 54);
        chk("held_second_clear", clr_q[4], T + 55);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        step(2);
        chk("start_abort_busy", int'(busy0), 0);

        // asynchronous reset in mid-run
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        #2 rst = 1'b0;
        #1;
        chk("areset_sys", int'(sys0), 0);
        chk("areset_busy", int'(busy0), 0);
        chk("areset_ia", int'(ia0), 25);
        chk("areset_fa1", int'(fa1), 25);
        @(posedge clk);
        #1 rst = 1'b1;
        step(2);

        // randomized traffic with random operand data
        for (int i = 0; i < 16; i++) av[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) bv[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 249) == 0);
            step(1);
        end
        start = 1'b0;
        abort = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
